// File: rtl/cv32e40p_recovery_ctrl_if.sv
// Recovery port bundle between cv32e40p_core and cv32e40p_recovery_ctrl.
// The core side uses modport master. The recovery controller uses modport slave.
interface cv32e40p_recovery_ctrl_if;
    // Core -> controller: request, RF write snoop, PC/CSR backup
    logic        recovery_req_i;
    logic        regfile_we_a_i;
    logic [5:0]  regfile_waddr_a_i;
    logic [31:0] regfile_wdata_a_i;
    logic        regfile_we_b_i;
    logic [5:0]  regfile_waddr_b_i;
    logic [31:0] regfile_wdata_b_i;
    logic [31:0] backup_program_counter_i;
    logic        backup_branch_i;
    logic [31:0] backup_branch_addr_i;
    logic [6:0]  backup_mstatus_i;
    logic [31:0] backup_mie_i;
    logic [23:0] backup_mtvec_i;
    logic [31:0] backup_mscratch_i;
    logic [31:0] backup_mip_i;
    logic [31:0] backup_mepc_i;
    logic [5:0]  backup_mcause_i;

    // Controller -> core: setback, RF replay, PC/CSR restore, status
    logic        setback_o;
    logic        recover_o;
    logic        regfile_we_a_o;
    logic [5:0]  regfile_waddr_a_o;
    logic [31:0] regfile_wdata_a_o;
    logic        regfile_we_b_o;
    logic [5:0]  regfile_waddr_b_o;
    logic [31:0] regfile_wdata_b_o;
    logic        pc_recover_o;
    logic [31:0] recovery_program_counter_o;
    logic        recovery_branch_o;
    logic [31:0] recovery_branch_addr_o;
    logic [6:0]  recovery_mstatus_o;
    logic [31:0] recovery_mie_o;
    logic [23:0] recovery_mtvec_o;
    logic [31:0] recovery_mscratch_o;
    logic [31:0] recovery_mip_o;
    logic [31:0] recovery_mepc_o;
    logic [5:0]  recovery_mcause_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  recovery_count_o;

    modport master (
        output recovery_req_i,
        output regfile_we_a_i, regfile_waddr_a_i, regfile_wdata_a_i,
        output regfile_we_b_i, regfile_waddr_b_i, regfile_wdata_b_i,
        output backup_program_counter_i, backup_branch_i, backup_branch_addr_i,
        output backup_mstatus_i, backup_mie_i, backup_mtvec_i, backup_mscratch_i,
        output backup_mip_i, backup_mepc_i, backup_mcause_i,
        input  setback_o, recover_o,
        input  regfile_we_a_o, regfile_waddr_a_o, regfile_wdata_a_o,
        input  regfile_we_b_o, regfile_waddr_b_o, regfile_wdata_b_o,
        input  pc_recover_o, recovery_program_counter_o, recovery_branch_o,
        input  recovery_branch_addr_o, recovery_mstatus_o, recovery_mie_o,
        input  recovery_mtvec_o, recovery_mscratch_o, recovery_mip_o,
        input  recovery_mepc_o, recovery_mcause_o,
        input  busy_o, done_o, recovery_count_o
    );

    modport slave (
        input  recovery_req_i,
        input  regfile_we_a_i, regfile_waddr_a_i, regfile_wdata_a_i,
        input  regfile_we_b_i, regfile_waddr_b_i, regfile_wdata_b_i,
        input  backup_program_counter_i, backup_branch_i, backup_branch_addr_i,
        input  backup_mstatus_i, backup_mie_i, backup_mtvec_i, backup_mscratch_i,
        input  backup_mip_i, backup_mepc_i, backup_mcause_i,
        output setback_o, recover_o,
        output regfile_we_a_o, regfile_waddr_a_o, regfile_wdata_a_o,
        output regfile_we_b_o, regfile_waddr_b_o, regfile_wdata_b_o,
        output pc_recover_o, recovery_program_counter_o, recovery_branch_o,
        output recovery_branch_addr_o, recovery_mstatus_o, recovery_mie_o,
        output recovery_mtvec_o, recovery_mscratch_o, recovery_mip_o,
        output recovery_mepc_o, recovery_mcause_o,
        output busy_o, done_o, recovery_count_o
    );
endinterface

// File: rtl/cv32e40p_recovery_ctrl.sv
// Recovery controller for one cv32e40p_core.
// Snoops committed GPR writes and PC/CSR backups into shadow state while idle.
// On a request it sets the core back, replays x0..x31 two registers per cycle
// (x(2k) on port A, x(2k+1) on port B), restores PC/CSRs and releases the core.
// Optional build macro CV32E40P_RECOVERY_COUNTER_EN adds an 8-bit saturating
// count of completed recoveries. Without it recovery_count_o is tied to 0.
module cv32e40p_recovery_ctrl (
    input  logic                           clk_i,
    input  logic                           rst_i,
    cv32e40p_recovery_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {StIdle, StSetback, StRestoreRf, StRestorePc} state_e;

    state_e      state_q;
    logic [3:0]  k_q;          // index of the register pair currently on the write ports
    logic        setback_q;
    logic        recover_q;
    logic        busy_q;
    logic        done_q;
    logic        pc_recover_q;
    logic        we_a_q;
    logic [5:0]  waddr_a_q;
    logic [31:0] wdata_a_q;
    logic        we_b_q;
    logic [5:0]  waddr_b_q;
    logic [31:0] wdata_b_q;

    // Shadow state. Entry 0 is cleared on reset and never written, so it always reads 0.
    logic [31:0] shadow_rf_q [32];
    logic [31:0] shadow_pc_q;
    logic        shadow_branch_q;
    logic [31:0] shadow_branch_addr_q;
    logic [6:0]  shadow_mstatus_q;
    logic [31:0] shadow_mie_q;
    logic [23:0] shadow_mtvec_q;
    logic [31:0] shadow_mscratch_q;
    logic [31:0] shadow_mip_q;
    logic [31:0] shadow_mepc_q;
    logic [5:0]  shadow_mcause_q;

    logic        idle;
    logic [3:0]  pair_k;
    logic [4:0]  pair_idx_a;
    logic [4:0]  pair_idx_b;
    logic [31:0] pair_rdata_a;
    logic [31:0] pair_rdata_b;

    assign idle = (state_q == StIdle);

    // Select the register pair to present on the next cycle's write ports.
    always_comb begin
        pair_k       = 4'd0;
        if (state_q == StRestoreRf) begin
            pair_k = k_q + 4'd1;
        end
        pair_idx_a   = {pair_k, 1'b0};
        pair_idx_b   = {pair_k, 1'b1};
        pair_rdata_a = shadow_rf_q[pair_idx_a];
        pair_rdata_b = shadow_rf_q[pair_idx_b];
    end

    // Shadow capture: GPR writes and PC/CSR backups, only while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                shadow_rf_q[i] <= '0;
            end
            shadow_pc_q          <= '0;
            shadow_branch_q      <= 1'b0;
            shadow_branch_addr_q <= '0;
            shadow_mstatus_q     <= '0;
            shadow_mie_q         <= '0;
            shadow_mtvec_q       <= '0;
            shadow_mscratch_q    <= '0;
            shadow_mip_q         <= '0;
            shadow_mepc_q        <= '0;
            shadow_mcause_q      <= '0;
        end else if (idle) begin
            // Matching only 1..31 drops FP writes (waddr[5]=1) and x0; port B is
            // assigned last so it wins a same-address collision.
            for (int i = 1; i < 32; i++) begin
                if (bus.regfile_we_a_i && (bus.regfile_waddr_a_i == 6'(i))) begin
                    shadow_rf_q[i] <= bus.regfile_wdata_a_i;
                end
                if (bus.regfile_we_b_i && (bus.regfile_waddr_b_i == 6'(i))) begin
                    shadow_rf_q[i] <= bus.regfile_wdata_b_i;
                end
            end
            shadow_pc_q          <= bus.backup_program_counter_i;
            shadow_branch_q      <= bus.backup_branch_i;
            shadow_branch_addr_q <= bus.backup_branch_addr_i;
            shadow_mstatus_q     <= bus.backup_mstatus_i;
            shadow_mie_q         <= bus.backup_mie_i;
            shadow_mtvec_q       <= bus.backup_mtvec_i;
            shadow_mscratch_q    <= bus.backup_mscratch_i;
            shadow_mip_q         <= bus.backup_mip_i;
            shadow_mepc_q        <= bus.backup_mepc_i;
            shadow_mcause_q      <= bus.backup_mcause_i;
        end
    end

    // Recovery sequencer with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            k_q          <= '0;
            setback_q    <= 1'b0;
            recover_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pc_recover_q <= 1'b0;
            we_a_q       <= 1'b0;
            waddr_a_q    <= '0;
            wdata_a_q    <= '0;
            we_b_q       <= 1'b0;
            waddr_b_q    <= '0;
            wdata_b_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.recovery_req_i) begin
                        state_q   <= StSetback;
                        k_q       <= '0;
                        setback_q <= 1'b1;
                        recover_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StSetback, StRestoreRf: begin
                    setback_q <= 1'b0;
                    if ((state_q == StRestoreRf) && (k_q == 4'd15)) begin
                        state_q      <= StRestorePc;
                        pc_recover_q <= 1'b1;
                        we_a_q       <= 1'b0;
                        waddr_a_q    <= '0;
                        wdata_a_q    <= '0;
                        we_b_q       <= 1'b0;
                        waddr_b_q    <= '0;
                        wdata_b_q    <= '0;
                    end else begin
                        state_q   <= StRestoreRf;
                        k_q       <= pair_k;
                        // Pair 0 carries x0 on port A, which must never be written.
                        we_a_q    <= (pair_k != 4'd0);
                        waddr_a_q <= {1'b0, pair_idx_a};
                        wdata_a_q <= pair_rdata_a;
                        we_b_q    <= 1'b1;
                        waddr_b_q <= {1'b0, pair_idx_b};
                        wdata_b_q <= pair_rdata_b;
                    end
                end
                StRestorePc: begin
                    state_q      <= StIdle;
                    pc_recover_q <= 1'b0;
                    recover_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CV32E40P_RECOVERY_COUNTER_EN
    logic [7:0] count_q;

    // Completed-recovery counter, saturating at 255.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if ((state_q == StRestorePc) && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign bus.recovery_count_o = count_q;
`else
    assign bus.recovery_count_o = 8'd0;
`endif

    assign bus.setback_o                  = setback_q;
    assign bus.recover_o                  = recover_q;
    assign bus.busy_o                     = busy_q;
    assign bus.done_o                     = done_q;
    assign bus.pc_recover_o               = pc_recover_q;
    assign bus.regfile_we_a_o             = we_a_q;
    assign bus.regfile_waddr_a_o          = waddr_a_q;
    assign bus.regfile_wdata_a_o          = wdata_a_q;
    assign bus.regfile_we_b_o             = we_b_q;
    assign bus.regfile_waddr_b_o          = waddr_b_q;
    assign bus.regfile_wdata_b_o          = wdata_b_q;
    assign bus.recovery_program_counter_o = shadow_pc_q;
    assign bus.recovery_branch_o          = shadow_branch_q;
    assign bus.recovery_branch_addr_o     = shadow_branch_addr_q;
    assign bus.recovery_mstatus_o         = shadow_mstatus_q;
    assign bus.recovery_mie_o             = shadow_mie_q;
    assign bus.recovery_mtvec_o           = shadow_mtvec_q;
    assign bus.recovery_mscratch_o        = shadow_mscratch_q;
    assign bus.recovery_mip_o             = shadow_mip_q;
    assign bus.recovery_mepc_o            = shadow_mepc_q;
    assign bus.recovery_mcause_o          = shadow_mcause_q;

endmodule

// File: doc/cv32e40p_recovery_ctrl.md
# cv32e40p_recovery_ctrl

Recovery controller on the core's backup/recovery port set. It snoops committed register-file writes and the program-counter and CSR backup outputs into a shadow state. On a recovery request it asserts setback, replays the shadow register file through the two recovery write ports, restores PC and CSRs, and then releases the core. It sits beside `cv32e40p_core`, one instance per core.

## Interface
Parameters:
- none. Shadow depth is fixed at 31 GPRs (x1..x31).

Ports:
- `clk_i` in 1: core clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `recovery_req_i` in 1: fault detected; sampled each cycle.
- `regfile_we_a_i`, `regfile_waddr_a_i`[5:0], `regfile_wdata_a_i`[31:0] in: core RF write port A snoop.
- `regfile_we_b_i`, `regfile_waddr_b_i`[5:0], `regfile_wdata_b_i`[31:0] in: core RF write port B snoop.
- `backup_program_counter_i`[31:0], `backup_branch_i`, `backup_branch_addr_i`[31:0] in: PC backup.
- `backup_mstatus_i`[6:0], `backup_mie_i`[31:0], `backup_mtvec_i`[23:0], `backup_mscratch_i`[31:0], `backup_mip_i`[31:0], `backup_mepc_i`[31:0], `backup_mcause_i`[5:0] in: CSR backup.
- `setback_o` out 1: core setback.
- `recover_o` out 1: core RF recovery mux select.
- `regfile_we_a_o`, `regfile_waddr_a_o`[5:0], `regfile_wdata_a_o`[31:0] out: recovery write port A.
- `regfile_we_b_o`, `regfile_waddr_b_o`[5:0], `regfile_wdata_b_o`[31:0] out: recovery write port B.
- `pc_recover_o`, `recovery_program_counter_o`[31:0], `recovery_branch_o`, `recovery_branch_addr_o`[31:0] out: PC restore.
- `recovery_mstatus_o` … `recovery_mcause_o` out, same widths as the backup inputs: CSR restore.
- `busy_o` out 1: recovery sequence active.
- `done_o` out 1: one-cycle pulse at end of sequence.
- `recovery_count_o` out 8: completed recoveries, saturating.

## Operation
- Shadow capture happens only in IDLE.
  - A write is captured when `we` is set, `waddr[5]`=0 and `waddr[4:0]`≠0.
  - Writes with `waddr[5]`=1 (FP) and writes to x0 are ignored.
  - If both ports write the same address in one cycle, port B wins.
- PC and CSR backups are registered every IDLE cycle.
- FSM states: IDLE, SETBACK, RESTORE_RF, RESTORE_PC.
- IDLE → SETBACK when `recovery_req_i`=1. Writes and backups in the request cycle are still captured.
- SETBACK (1 cycle):
  - `setback_o`=1, `recover_o`=1.
  - Index counter k is cleared to 0.
  - Next state RESTORE_RF.
- RESTORE_RF (16 cycles, k=0..15):
  - Port A writes x(2k) and port B writes x(2k+1), each with the shadow value.
  - `regfile_we_a_o`=0 when k=0, so x0 is never written.
  - Addresses are zero-extended to 6 bits.
  - After k=15, next state RESTORE_PC.
- RESTORE_PC (1 cycle):
  - `pc_recover_o`=1.
  - `recovery_*` PC and CSR outputs drive the shadow values.
  - Next state IDLE.
  - `done_o` pulses and `recovery_count_o` increments, saturating at 255.
- `recovery_*` CSR and PC outputs hold the shadow values in all states.
- `recover_o`=1 and `busy_o`=1 from SETBACK through RESTORE_PC.
- `recovery_req_i` while busy is ignored. It is not queued.
- All outputs are registered.

## Timing
- Reset values: all outputs 0, shadow RF 0, shadow PC/CSR 0, FSM in IDLE.
- Reset mid-sequence aborts immediately to IDLE; outputs go to 0 asynchronously.
- Cycle numbering for a request sampled in cycle N:
  - N+1: `setback_o` high.
  - N+2..N+17: RF write pairs.
  - N+18: `pc_recover_o` high.
  - N+19: `done_o` high, `busy_o` low, new requests accepted again.
- Total busy time is 18 cycles.
- Outside RESTORE_RF, `regfile_we_a_o` and `regfile_we_b_o` are 0. Their address and data outputs are 0 outside RESTORE_RF.

## Configuration
- `CV32E40P_RECOVERY_COUNTER_EN` defined: the 8-bit saturating counter is present.
- Undefined: `recovery_count_o` is tied to 0 and no counter flop exists.
- FSM timing is identical in both builds.

## Test plan
- Reset and capture: reset, write x5=0xDEADBEEF on port A, request recovery → cycle N+4 (k=2) shows B port addr 5, data 0xDEADBEEF, `we_b`=1.
- x0 and FP filtering: write x0=0x1 and waddr 0x21=0x2, then recover → k=0 shows `we_a`=0; no restored value ever shows 0x2.
- Same-address collision: A and B both write x7 in one cycle, A=0x11 and B=0x22 → the restored x7 is 0x22.
- Full sequence: backup PC=0x1C00_0080, mepc=0x1C00_0040 → `setback_o` at N+1, `pc_recover_o` at N+18 with PC 0x1C00_0080 and mepc 0x1C00_0040, `done_o` at N+19.
- Busy request ignored: re-assert `recovery_req_i` at N+5 → exactly one `done_o`; `recovery_count_o` goes 0→1 (stays 0 without the macro).
- Reset mid-sequence: assert `rst_i` at N+10 → all outputs 0 in the same cycle; after release, FSM is IDLE and shadow state is 0.
